// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// XZR (index 31) reads are answered locally with zero and never occupy the port.
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  input  logic              port_avail,
  output logic [4:0]        port_sel,
  input  logic [DW-1:0]     port_data,
  output logic [NREQ-1:0]   resp_valid,
  output logic [DW*NREQ-1:0] resp_data
);

  localparam int         PW  = $clog2(NREQ);
  localparam logic [4:0] XZR = 5'd31;

  typedef logic [PW-1:0] ptr_t;

  ptr_t                      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]           resp_valid_q, resp_valid_d;
  logic [NREQ-1:0][DW-1:0]   resp_data_q, resp_data_d;

  logic [NREQ-1:0] is_xzr;
  logic [NREQ-1:0] port_req;
  logic [NREQ-1:0] port_grant;
  logic            win_found;
  ptr_t            win_idx;

  // Request decode; reset_n gates everything so no grant is visible in reset.
  always_comb begin
    is_xzr   = '0;
    port_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      is_xzr[i]   = reset_n & req_valid[i] & (req_addr[5*i +: 5] == XZR);
      port_req[i] = reset_n & req_valid[i] & (req_addr[5*i +: 5] != XZR) & port_avail;
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NREQ) for the first port request.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && port_req[ptr_t'(idx)]) begin
        win_found = 1'b1;
        win_idx   = ptr_t'(idx);
      end
    end
  end

  always_comb begin
    port_grant = '0;
    port_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_found && (win_idx == ptr_t'(i))) begin
        port_grant[i] = 1'b1;
        port_sel      = req_addr[5*i +: 5];
      end
    end
  end

  assign req_ready = is_xzr | port_grant;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = req_ready;
    resp_data_d  = resp_data_q;
    if (win_found) begin
      rr_ptr_d = (win_idx == ptr_t'(NREQ-1)) ? '0 : ptr_t'(win_idx + 1'b1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (is_xzr[i])          resp_data_d[i] = '0;
      else if (port_grant[i]) resp_data_d[i] = port_data;
    end
  end

  // NOTE: the response data registers are reset too, because their value is
  // architecturally visible (zero) straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed and randomised checks of regfile_read_arbiter against hand-derived
// expectations and a reference register file driving the port mux.
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              port_avail;
  logic [4:0]        port_sel;
  logic [DW-1:0]     port_data;
  logic [NREQ-1:0]   resp_valid;
  logic [DW*NREQ-1:0] resp_data;

  logic [DW-1:0] rf [32];
  int vec_cnt = 0;
  int err_cnt = 0;

  regfile_read_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .port_avail (port_avail),
    .port_sel   (port_sel),
    .port_data  (port_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  // Reference register file behind the shared read port.
  assign port_data = rf[port_sel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a);
    req_valid[i]        = 1'b1;
    req_addr[5*i +: 5]  = a;
  endtask

  function automatic logic [63:0] rd(input int i);
    return resp_data[DW*i +: DW];
  endfunction

  task automatic do_reset();
    req_valid = '0;
    #1 reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int          wait_cnt [NREQ];
    logic [NREQ-1:0] pg, exp_v;
    logic [63:0] exp_d [NREQ];
    logic        any_port;
    logic [4:0]  a;

    for (int k = 0; k < 32; k++) rf[k] = {$urandom(), $urandom()};
    rf[5]  = 64'hA5;
    rf[31] = '1;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

    req_valid  = '0;
    req_addr   = '0;
    port_avail = 1'b1;
    reset_n    = 1'b0;

    // Reset: combinational outputs forced low, registers cleared.
    set_req(0, 5);
    #2;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_sel", 64'(port_sel), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_data", 64'(|resp_data), 64'h0);
    req_valid = '0;
    #3 reset_n = 1'b1;
    tick();

    // Single request.
    set_req(0, 5);
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_sel", 64'(port_sel), 64'd5);
    tick();
    req_valid[0] = 1'b0;
    check("single_resp_valid", 64'(resp_valid), 64'h1);
    check("single_resp_data", rd(0), 64'hA5);
    tick();
    check("single_resp_drop", 64'(resp_valid), 64'h0);

    // Round-robin contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1));
    for (int k = 0; k < NREQ; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(1 << k));
      check("rr_sel", 64'(port_sel), 64'(k + 1));
      tick();
      req_valid[k] = 1'b0;
      check("rr_resp_valid", 64'(resp_valid), 64'(1 << k));
      check("rr_resp_data", rd(k), rf[k+1]);
    end
    set_req(0, 20);
    set_req(3, 21);
    #1;
    check("wrap_ready0", 64'(req_ready), 64'h1);
    check("wrap_sel0", 64'(port_sel), 64'd20);
    tick();
    req_valid[0] = 1'b0;
    check("wrap_data0", rd(0), rf[20]);
    #1;
    check("wrap_ready3", 64'(req_ready), 64'h8);
    check("wrap_sel3", 64'(port_sel), 64'd21);
    tick();
    req_valid[3] = 1'b0;
    check("wrap_data3", rd(3), rf[21]);

    // XZR bypass while the port is claimed elsewhere.
    port_avail = 1'b0;
    set_req(0, 31);
    set_req(1, 7);
    #1;
    check("xzr_ready", 64'(req_ready), 64'h1);
    check("xzr_sel", 64'(port_sel), 64'h0);
    tick();
    req_valid[0] = 1'b0;
    check("xzr_resp_valid", 64'(resp_valid), 64'h1);
    check("xzr_resp_data", rd(0), 64'h0);
    #1;
    check("xzr_hold_ready", 64'(req_ready), 64'h0);
    tick();
    check("xzr_hold_resp", 64'(resp_valid), 64'h0);
    port_avail = 1'b1;
    #1;
    check("xzr_port_ready", 64'(req_ready), 64'h2);
    check("xzr_port_sel", 64'(port_sel), 64'd7);
    tick();
    req_valid[1] = 1'b0;
    check("xzr_port_data", rd(1), rf[7]);

    // XZR completion leaves the pointer at 2, so requester 2 beats 3.
    set_req(2, 31);
    #1;
    check("ptr_xzr_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid[2] = 1'b0;
    check("ptr_xzr_data", rd(2), 64'h0);
    set_req(2, 10);
    set_req(3, 11);
    #1;
    check("ptr_keep_ready", 64'(req_ready), 64'h4);
    check("ptr_keep_sel", 64'(port_sel), 64'd10);
    tick();
    req_valid[2] = 1'b0;
    check("ptr_keep_data", rd(2), rf[10]);
    #1;
    check("ptr_next_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid[3] = 1'b0;
    check("ptr_next_data", rd(3), rf[11]);

    // Port blocked for three cycles.
    port_avail = 1'b0;
    set_req(2, 9);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("blk_ready", 64'(req_ready), 64'h0);
      check("blk_sel", 64'(port_sel), 64'h0);
      tick();
      check("blk_resp", 64'(resp_valid), 64'h0);
    end
    port_avail = 1'b1;
    #1;
    check("blk_rise_ready", 64'(req_ready), 64'h4);
    check("blk_rise_sel", 64'(port_sel), 64'd9);
    tick();
    req_valid[2] = 1'b0;
    check("blk_rise_data", rd(2), rf[9]);

    // Reset between grant and the completing edge drops the response.
    set_req(1, 6);
    #1;
    check("mid_grant", 64'(req_ready), 64'h2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    check("mid_rst_resp", 64'(resp_valid), 64'h0);
    check("mid_rst_data", 64'(|resp_data), 64'h0);
    tick();
    check("mid_rst_edge", 64'(resp_valid), 64'h0);
    req_valid = '0;
    #2 reset_n = 1'b1;
    tick();
    check("mid_rel_resp", 64'(resp_valid), 64'h0);
    check("mid_rel_data", 64'(|resp_data), 64'h0);
    set_req(3, 13);
    #1;
    check("mid_fresh_ready", 64'(req_ready), 64'h8);
    check("mid_fresh_sel", 64'(port_sel), 64'd13);
    tick();
    req_valid[3] = 1'b0;
    check("mid_fresh_resp", 64'(resp_valid), 64'h8);
    check("mid_fresh_data", rd(3), rf[13]);

    // Randomised soak; requests are held until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          a = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
          set_req(i, a);
        end
      end
      port_avail = ($urandom_range(0, 3) != 0);
      #1;
      exp_v    = '0;
      pg       = '0;
      any_port = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        exp_d[i] = '0;
        if (req_valid[i] && req_addr[5*i +: 5] == 5'd31) begin
          check("soak_xzr_ready", 64'(req_ready[i]), 64'h1);
          exp_v[i] = 1'b1;
        end else if (req_valid[i]) begin
          any_port = 1'b1;
          if (req_ready[i]) pg[i] = 1'b1;
        end
      end
      check("soak_spurious", 64'(req_ready & ~req_valid), 64'h0);
      check("soak_onehot", 64'($countones(pg) <= 1), 64'h1);
      check("soak_grant", 64'(pg != '0), 64'(port_avail && any_port));
      if (pg == '0) check("soak_idle_sel", 64'(port_sel), 64'h0);
      for (int i = 0; i < NREQ; i++) begin
        if (pg[i]) begin
          check("soak_sel", 64'(port_sel), 64'(req_addr[5*i +: 5]));
          exp_v[i] = 1'b1;
          exp_d[i] = rf[req_addr[5*i +: 5]];
        end
        if (req_valid[i] && req_addr[5*i +: 5] != 5'd31 && port_avail) begin
          wait_cnt[i]++;
          check("soak_starve", 64'(wait_cnt[i] <= NREQ), 64'h1);
        end
      end
      tick();
      check("soak_resp_valid", 64'(resp_valid), 64'(exp_v));
      for (int i = 0; i < NREQ; i++) begin
        if (exp_v[i]) begin
          check("soak_resp_data", rd(i), exp_d[i]);
          req_valid[i] = 1'b0;
          wait_cnt[i]  = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
